picorv32_wb_bridge: RTL and testbench
=====================================

# picorv32_wb_bridge

Converts the picorv32 native memory interface (mem_valid/mem_ready) into a classic-cycle 32-bit Wishbone master that drives the SoC Wishbone interconnect's picorv32 master port. Issues one single-beat transfer per CPU request. Handles slave retry with a bounded retry count, and terminates hung or errored cycles with a bus-error completion so the CPU never stalls forever.

## Interface
- TIMEOUT_CYCLES, 255: maximum cycles cyc/stb may stay high without ack/err/rty before forced termination (1..65535).
- RTY_LIMIT, 3: number of re-issues after rty before the request is failed (0..15).
- ERR_RDATA, 32'hDEAD_BEEF: value returned on mem_rdata for a failed read.
- wb_clk_i  in  1  system clock; all logic on its rising edge.
- wb_rst_n_i  in  1  asynchronous, active-low reset.
- mem_valid_i  in  1  CPU request valid.
- mem_instr_i  in  1  request is an instruction fetch (informational; latched into err status).
- mem_addr_i  in  32  byte address.
- mem_wdata_i  in  32  write data.
- mem_wstrb_i  in  4  byte strobes; 0 = read, nonzero = write.
- mem_ready_o  out  1  one-cycle completion pulse.
- mem_rdata_o  out  32  read data, valid while mem_ready_o=1.
- wbm_adr_o / wbm_dat_o  out  32 / 32  Wishbone address / write data.
- wbm_sel_o  out  4  byte selects.
- wbm_we_o, wbm_cyc_o, wbm_stb_o  out  1 each.
- wbm_cti_o  out  3  constant 3'b000; wbm_bte_o  out  2  constant 2'b00.
- wbm_dat_i  in  32; wbm_ack_i, wbm_err_i, wbm_rty_i  in  1 each.
- bus_err_o  out  1  one-cycle pulse when a request fails (err, timeout, or retry exhaustion).
- err_addr_o  out  32  address of the most recent failed request (held).
- err_cause_o  out  3  {instr, cause[1:0]} of last failure; cause 01=err, 10=timeout, 11=retry exhausted.

## Operation
- States: IDLE, BUS, BACKOFF, DONE.
- IDLE: if mem_valid_i, latch addr/wdata/wstrb/instr and drive adr=addr, dat=wdata, we=|wstrb, sel=wstrb (sel=4'hF for reads); cyc=stb=1; clear timeout and retry counters; go to BUS.
- BUS: hold all master outputs stable. Priority when several inputs are set in one cycle: err > ack > rty.
  - ack: capture wbm_dat_i into mem_rdata (reads; writes return 0); drop cyc/stb; mem_ready_o=1 next cycle; go to DONE.
  - err, or timeout counter reaching TIMEOUT_CYCLES-1 with no termination: drop cyc/stb; mem_rdata=ERR_RDATA (reads), mem_ready_o=1, bus_err_o=1; update err_addr_o/err_cause_o; go to DONE.
  - rty: if retry count < RTY_LIMIT, increment it, drop cyc/stb, go to BACKOFF. Otherwise fail with cause 11, as for err.
- BACKOFF: one cycle with cyc=stb=0; reassert cyc/stb with the same latched request; reset timeout counter; go to BUS.
- DONE: one cycle, cyc=stb=0, ignore mem_valid_i (picorv32 still shows the old valid that cycle); go to IDLE.
- Latched request is not re-sampled during BUS/BACKOFF; mem_* input changes mid-transfer are ignored.
- Timeout counter: 16 bits, saturating, counts cycles in BUS.

## Timing
- Reset (async assert, sync to clock on release): state=IDLE; cyc/stb/we=0; adr/dat/sel=0; mem_ready_o=0; mem_rdata_o=0; bus_err_o=0; err_addr_o=0; err_cause_o=0; counters 0.
- Reset mid-transfer: cyc/stb fall immediately (async); no mem_ready_o is produced; request is lost.
- Latency: mem_valid_i sampled at edge 0 -> cyc/stb high after edge 0. A slave ack seen at edge k -> mem_ready_o high for exactly the cycle after edge k, cyc/stb low in that same cycle. Zero-wait slave (ack at edge 1): mem_ready_o after edge 1. Back-to-back requests are at least 3 cycles apart (BUS, DONE, IDLE).
- Each rty costs 2 extra cycles (the rty cycle, then BACKOFF).
- Timeout: with no response, mem_ready_o and bus_err_o fire TIMEOUT_CYCLES cycles after cyc rises.
- mem_ready_o and bus_err_o are single-cycle pulses that coincide on failure.
- Ack/err/rty arriving while cyc=0 are ignored.

## Test plan
- Read, slave acks after 2 wait states, dat=32'h1234_5678 -> cyc high 3 cycles, sel=4'hF, we=0; mem_ready_o one cycle with mem_rdata_o=32'h1234_5678; bus_err_o=0.
- Byte write wstrb=4'b0100 to 32'h0000_1002 -> sel=4'b0100, we=1, dat=wdata; mem_ready_o pulses after ack; no second cycle while mem_valid_i is held through DONE.
- Slave asserts rty twice, then ack (RTY_LIMIT=3) -> cyc drops 1 cycle twice; the third cycle completes normally with no bus_err_o.
- rty on every attempt (RTY_LIMIT=3) -> 4 cycles issued, then mem_ready_o+bus_err_o, err_cause_o=3'b011 (data access), err_addr_o=request address.
- No response with TIMEOUT_CYCLES=16 on an instruction fetch -> completion 16 cycles after cyc rises, mem_rdata_o=32'hDEAD_BEEF, err_cause_o=3'b110.
- err and ack asserted together -> treated as err; reset asserted while in BUS -> cyc/stb low without waiting for a clock edge, no mem_ready_o.

Source files
------------

// File: rtl/picorv32_wb_bridge.sv
// Bridges the picorv32 native memory interface to a classic-cycle Wishbone master.
// One single-beat transfer per request, with bounded retry and error/timeout termination.
module picorv32_wb_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned RTY_LIMIT      = 3,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        mem_valid_i,
    input  logic        mem_instr_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_wstrb_i,
    output logic        mem_ready_o,
    output logic [31:0] mem_rdata_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic [2:0]  wbm_cti_o,
    output logic [1:0]  wbm_bte_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic        wbm_rty_i,
    output logic        bus_err_o,
    output logic [31:0] err_addr_o,
    output logic [2:0]  err_cause_o
);
    localparam logic [15:0] TmoLast  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  RtyMax   = 4'(RTY_LIMIT);
    localparam logic [1:0]  CauseErr = 2'b01;
    localparam logic [1:0]  CauseTmo = 2'b10;
    localparam logic [1:0]  CauseRty = 2'b11;

    typedef enum logic [1:0] {StIdle, StBus, StBackoff, StDone} state_e;

    state_e      state;
    logic        req_instr;
    logic [15:0] tmo_cnt;
    logic [3:0]  rty_cnt;
    logic        fail;
    logic [1:0]  fail_cause;

    assign wbm_cti_o = 3'b000;
    assign wbm_bte_o = 2'b00;

    // Failure decode for the BUS state; err outranks ack, ack outranks rty.
    always_comb begin
        fail       = 1'b0;
        fail_cause = CauseErr;
        if (wbm_err_i) begin
            fail = 1'b1;
        end else if (!wbm_ack_i && wbm_rty_i && (rty_cnt >= RtyMax)) begin
            fail       = 1'b1;
            fail_cause = CauseRty;
        end else if (!wbm_ack_i && !wbm_rty_i && (tmo_cnt == TmoLast)) begin
            fail       = 1'b1;
            fail_cause = CauseTmo;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state       <= StIdle;
            req_instr   <= 1'b0;
            tmo_cnt     <= 16'd0;
            rty_cnt     <= 4'd0;
            wbm_adr_o   <= 32'd0;
            wbm_dat_o   <= 32'd0;
            wbm_sel_o   <= 4'd0;
            wbm_we_o    <= 1'b0;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            mem_ready_o <= 1'b0;
            mem_rdata_o <= 32'd0;
            bus_err_o   <= 1'b0;
            err_addr_o  <= 32'd0;
            err_cause_o <= 3'd0;
        end else begin
            mem_ready_o <= 1'b0;
            bus_err_o   <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (mem_valid_i) begin
                        wbm_adr_o <= mem_addr_i;
                        wbm_dat_o <= mem_wdata_i;
                        wbm_we_o  <= |mem_wstrb_i;
                        wbm_sel_o <= (mem_wstrb_i == 4'd0) ? 4'hF : mem_wstrb_i;
                        req_instr <= mem_instr_i;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        tmo_cnt   <= 16'd0;
                        rty_cnt   <= 4'd0;
                        state     <= StBus;
                    end
                end
                StBus: begin
                    if (fail) begin
                        wbm_cyc_o   <= 1'b0;
                        wbm_stb_o   <= 1'b0;
                        mem_ready_o <= 1'b1;
                        bus_err_o   <= 1'b1;
                        mem_rdata_o <= wbm_we_o ? 32'd0 : ERR_RDATA;
                        err_addr_o  <= wbm_adr_o;
                        err_cause_o <= {req_instr, fail_cause};
                        state       <= StDone;
                    end else if (wbm_ack_i) begin
                        wbm_cyc_o   <= 1'b0;
                        wbm_stb_o   <= 1'b0;
                        mem_ready_o <= 1'b1;
                        mem_rdata_o <= wbm_we_o ? 32'd0 : wbm_dat_i;
                        state       <= StDone;
                    end else if (wbm_rty_i) begin
                        rty_cnt   <= rty_cnt + 4'd1;
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        state     <= StBackoff;
                    end else if (tmo_cnt != 16'hFFFF) begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                StBackoff: begin
                    wbm_cyc_o <= 1'b1;
                    wbm_stb_o <= 1'b1;
                    tmo_cnt   <= 16'd0;
                    state     <= StBus;
                end
                StDone: begin
                    // picorv32 still presents the completed request this cycle
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_picorv32_wb_bridge.sv
// Randomized bench for picorv32_wb_bridge: scripted Wishbone slave responses,
// checked against a transaction-level model of latency, data and error reporting.
module tb_picorv32_wb_bridge;
    localparam int unsigned TMO  = 16;
    localparam int unsigned RTY  = 3;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
    localparam int TermAck = 0, TermErr = 1, TermRty = 2, TermNone = 3, TermErrAck = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_valid = 1'b0, mem_instr = 1'b0;
    logic [31:0] mem_addr = '0, mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        mem_ready;
    logic [31:0] mem_rdata, wbm_adr, wbm_dat;
    logic [3:0]  wbm_sel;
    logic        wbm_we, wbm_cyc, wbm_stb;
    logic [2:0]  wbm_cti;
    logic [1:0]  wbm_bte;
    logic [31:0] wbm_dat_in = '0;
    logic        wbm_ack = 1'b0, wbm_err = 1'b0, wbm_rty = 1'b0;
    logic        bus_err;
    logic [31:0] err_addr;
    logic [2:0]  err_cause;

    always #5 clk = ~clk;

    picorv32_wb_bridge #(.TIMEOUT_CYCLES(TMO), .RTY_LIMIT(RTY), .ERR_RDATA(ERRD)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .mem_valid_i(mem_valid), .mem_instr_i(mem_instr), .mem_addr_i(mem_addr),
        .mem_wdata_i(mem_wdata), .mem_wstrb_i(mem_wstrb), .mem_ready_o(mem_ready),
        .mem_rdata_o(mem_rdata), .wbm_adr_o(wbm_adr), .wbm_dat_o(wbm_dat), .wbm_sel_o(wbm_sel),
        .wbm_we_o(wbm_we), .wbm_cyc_o(wbm_cyc), .wbm_stb_o(wbm_stb), .wbm_cti_o(wbm_cti),
        .wbm_bte_o(wbm_bte), .wbm_dat_i(wbm_dat_in), .wbm_ack_i(wbm_ack), .wbm_err_i(wbm_err),
        .wbm_rty_i(wbm_rty), .bus_err_o(bus_err), .err_addr_o(err_addr), .err_cause_o(err_cause)
    );

    int n_checks = 0, n_fail = 0;
    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // Slave script: per attempt, wait states then a terminating response
    int   scr_wait[8];
    int   scr_term[8];
    int   scr_len = 0;
    logic noise = 1'b0;

    logic [31:0] mdl_err_addr = '0;
    logic [2:0]  mdl_err_cause = '0;
    int          exp_lat, exp_attempts, exp_cyc;
    logic [31:0] exp_rdata;
    logic        exp_berr;

    int          obs_lat, obs_attempts, obs_cyc, obs_unstable, obs_extra, obs_accept;
    logic [31:0] obs_rdata, obs_adr, obs_dat, obs_eaddr;
    logic [3:0]  obs_sel;
    logic        obs_we, obs_berr;
    logic [2:0]  obs_cause;

    task automatic model_txn(input logic [31:0] addr, input logic [3:0] wstrb,
                             input logic instr, input logic [31:0] sdat);
        int start, retries, c, term, w;
        logic done;
        start = 0; retries = 0; done = 1'b0;
        exp_cyc = 0; exp_berr = 1'b0; exp_attempts = 0; exp_lat = 0;
        for (int a = 0; a < 8 && !done; a++) begin
            term = (a < scr_len) ? scr_term[a] : TermNone;
            w    = (a < scr_len) ? scr_wait[a] : 0;
            if (term == TermNone || w >= int'(TMO)) begin
                c = TMO;
                term = TermNone;
            end else begin
                c = w + 1;
            end
            exp_cyc += c;
            exp_attempts = a + 1;
            exp_lat = start + c;
            done = 1'b1;
            case (term)
                TermNone: begin exp_berr = 1'b1; mdl_err_cause = {instr, 2'b10}; end
                TermAck:  exp_berr = 1'b0;
                TermRty: begin
                    if (retries < int'(RTY)) begin
                        retries++;
                        start = start + c + 1;
                        done = 1'b0;
                    end else begin
                        exp_berr = 1'b1;
                        mdl_err_cause = {instr, 2'b11};
                    end
                end
                default: begin exp_berr = 1'b1; mdl_err_cause = {instr, 2'b01}; end
            endcase
        end
        if (exp_berr) mdl_err_addr = addr;
        exp_rdata = (wstrb != 4'd0) ? 32'd0 : (exp_berr ? ERRD : sdat);
    endtask

    // Caller must be at a negedge; returns at the negedge after the DONE cycle.
    task automatic do_txn(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic instr, input logic [31:0] sdat);
        int a, m;
        logic prev_cyc, seen;
        a = -1; m = 0; prev_cyc = 1'b0; seen = 1'b0;
        obs_lat = -1; obs_cyc = 0; obs_unstable = 0; obs_extra = 0;
        mem_valid = 1'b1; mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb;
        mem_instr = instr;
        {wbm_ack, wbm_err, wbm_rty} = noise ? 3'($urandom) : 3'b000;
        @(posedge clk);
        obs_accept = cycle;
        for (int j = 0; j < 400; j++) begin
            @(negedge clk);
            if (mem_ready) begin
                obs_lat = j; obs_rdata = mem_rdata; obs_berr = bus_err;
                obs_cause = err_cause; obs_eaddr = err_addr;
                if (wbm_cyc || wbm_stb) obs_extra++;
                break;
            end
            if (bus_err) obs_extra++;
            {wbm_ack, wbm_err, wbm_rty} = 3'b000;
            wbm_dat_in = $urandom;
            if (wbm_cyc) begin
                if (!prev_cyc) begin a++; m = 0; end
                m++; obs_cyc++;
                if (!seen) begin
                    obs_adr = wbm_adr; obs_dat = wbm_dat; obs_sel = wbm_sel; obs_we = wbm_we;
                    seen = 1'b1;
                end else if ({wbm_adr, wbm_dat, wbm_sel, wbm_we} !==
                             {obs_adr, obs_dat, obs_sel, obs_we}) begin
                    obs_unstable++;
                end
                if (wbm_stb !== 1'b1) obs_unstable++;
                if (a < scr_len && scr_term[a] != TermNone && m == scr_wait[a] + 1) begin
                    case (scr_term[a])
                        TermAck:    begin wbm_ack = 1'b1; wbm_dat_in = sdat; end
                        TermErr:    wbm_err = 1'b1;
                        TermRty:    wbm_rty = 1'b1;
                        default:    begin wbm_err = 1'b1; wbm_ack = 1'b1; wbm_dat_in = sdat; end
                    endcase
                end
            end else begin
                if (wbm_stb) obs_unstable++;
                if (noise) {wbm_ack, wbm_err, wbm_rty} = 3'($urandom);
            end
            prev_cyc = wbm_cyc;
            // mid-transfer request changes must not leak onto the bus
            mem_addr = $urandom; mem_wdata = $urandom; mem_wstrb = 4'($urandom);
            mem_instr = 1'($urandom);
        end
        obs_attempts = a + 1;
        {wbm_ack, wbm_err, wbm_rty} = 3'b000;
        @(negedge clk);
        if (mem_ready || bus_err || wbm_cyc || wbm_stb) obs_extra++;
        mem_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_checks++;
        if ({mem_ready, mem_rdata, wbm_adr, wbm_dat, wbm_sel, wbm_we, wbm_cyc, wbm_stb,
             bus_err, err_addr, err_cause} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got adr=%h cyc=%b ready=%b err_addr=%h, required all zero",
                     wbm_adr, wbm_cyc, mem_ready, err_addr);
        end
        n_checks++;
        if ({wbm_cti, wbm_bte} !== 5'd0) begin
            n_fail++; $display("FAIL reset_cti_bte: got %b required 00000", {wbm_cti, wbm_bte});
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read();
        logic [31:0] addr, wdata;
        addr = $urandom & 32'hFFFF_FFFC; wdata = $urandom;
        scr_len = 1; scr_wait[0] = 2; scr_term[0] = TermAck;
        model_txn(addr, 4'h0, 1'b0, 32'h1234_5678);
        do_txn(addr, wdata, 4'h0, 1'b0, 32'h1234_5678);
        n_checks++;
        if (obs_lat !== 3 || obs_lat !== exp_lat) begin
            n_fail++; $display("FAIL read_latency: got %0d required 3", obs_lat);
        end
        n_checks++;
        if (obs_cyc !== 3) begin n_fail++; $display("FAIL read_cyc_len: got %0d required 3", obs_cyc); end
        n_checks++;
        if ({obs_adr, obs_sel, obs_we} !== {addr, 4'hF, 1'b0}) begin
            n_fail++; $display("FAIL read_bus: got adr=%h sel=%h we=%b required adr=%h sel=f we=0",
                               obs_adr, obs_sel, obs_we, addr);
        end
        n_checks++;
        if (obs_rdata !== 32'h1234_5678 || obs_berr !== 1'b0) begin
            n_fail++; $display("FAIL read_data: got %h berr=%b required 12345678 berr=0",
                               obs_rdata, obs_berr);
        end
        n_checks++;
        if (obs_extra !== 0 || obs_unstable !== 0) begin
            n_fail++; $display("FAIL read_pulse: got extra=%0d unstable=%0d required 0/0",
                               obs_extra, obs_unstable);
        end
    endtask

    task automatic test_write_byte();
        logic [31:0] wdata;
        wdata = $urandom;
        scr_len = 1; scr_wait[0] = $urandom_range(0, 3); scr_term[0] = TermAck;
        model_txn(32'h0000_1002, 4'b0100, 1'b0, 32'h0);
        do_txn(32'h0000_1002, wdata, 4'b0100, 1'b0, 32'hCAFE_F00D);
        n_checks++;
        if ({obs_adr, obs_dat, obs_sel, obs_we} !== {32'h0000_1002, wdata, 4'b0100, 1'b1}) begin
            n_fail++; $display("FAIL write_bus: got adr=%h dat=%h sel=%b we=%b required %h %h 0100 1",
                               obs_adr, obs_dat, obs_sel, obs_we, 32'h0000_1002, wdata);
        end
        n_checks++;
        if (obs_lat !== exp_lat || obs_rdata !== 32'd0) begin
            n_fail++; $display("FAIL write_done: got lat=%0d rdata=%h required %0d 0",
                               obs_lat, obs_rdata, exp_lat);
        end
        n_checks++;
        if (obs_extra !== 0) begin
            n_fail++; $display("FAIL write_no_reissue: got %0d extra events required 0", obs_extra);
        end
    endtask

    task automatic test_retry_ok();
        logic [31:0] addr, sdat;
        addr = $urandom; sdat = $urandom;
        scr_len = 3;
        scr_wait[0] = 0; scr_term[0] = TermRty;
        scr_wait[1] = 1; scr_term[1] = TermRty;
        scr_wait[2] = 0; scr_term[2] = TermAck;
        model_txn(addr, 4'h0, 1'b0, sdat);
        do_txn(addr, $urandom, 4'h0, 1'b0, sdat);
        n_checks++;
        if (obs_attempts !== 3 || obs_lat !== exp_lat) begin
            n_fail++; $display("FAIL retry_ok_timing: got attempts=%0d lat=%0d required 3 %0d",
                               obs_attempts, obs_lat, exp_lat);
        end
        n_checks++;
        if (obs_berr !== 1'b0 || obs_rdata !== sdat || obs_unstable !== 0) begin
            n_fail++; $display("FAIL retry_ok_data: got berr=%b rdata=%h unstable=%0d required 0 %h 0",
                               obs_berr, obs_rdata, obs_unstable, sdat);
        end
    endtask

    task automatic test_retry_exhaust();
        logic [31:0] addr;
        addr = $urandom;
        scr_len = 4;
        for (int i = 0; i < 4; i++) begin scr_wait[i] = $urandom_range(0, 2); scr_term[i] = TermRty; end
        model_txn(addr, 4'h0, 1'b0, 32'h0);
        do_txn(addr, $urandom, 4'h0, 1'b0, 32'h0);
        n_checks++;
        if (obs_attempts !== 4 || obs_lat !== exp_lat) begin
            n_fail++; $display("FAIL retry_exh_timing: got attempts=%0d lat=%0d required 4 %0d",
                               obs_attempts, obs_lat, exp_lat);
        end
        n_checks++;
        if (obs_berr !== 1'b1 || obs_cause !== 3'b011 || obs_eaddr !== addr) begin
            n_fail++; $display("FAIL retry_exh_err: got berr=%b cause=%b addr=%h required 1 011 %h",
                               obs_berr, obs_cause, obs_eaddr, addr);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] addr;
        addr = $urandom;
        scr_len = 0;
        model_txn(addr, 4'h0, 1'b1, 32'h0);
        do_txn(addr, $urandom, 4'h0, 1'b1, 32'h0);
        n_checks++;
        if (obs_lat !== int'(TMO) || obs_cyc !== int'(TMO)) begin
            n_fail++; $display("FAIL timeout_timing: got lat=%0d cyc=%0d required %0d",
                               obs_lat, obs_cyc, TMO);
        end
        n_checks++;
        if (obs_rdata !== ERRD || obs_cause !== 3'b110 || obs_berr !== 1'b1) begin
            n_fail++; $display("FAIL timeout_err: got rdata=%h cause=%b berr=%b required deadbeef 110 1",
                               obs_rdata, obs_cause, obs_berr);
        end
        n_checks++;
        if (obs_eaddr !== addr) begin
            n_fail++; $display("FAIL timeout_addr: got %h required %h", obs_eaddr, addr);
        end
    endtask

    task automatic test_err_ack();
        logic [31:0] addr;
        logic        instr;
        addr = $urandom; instr = 1'($urandom);
        scr_len = 1; scr_wait[0] = 1; scr_term[0] = TermErrAck;
        model_txn(addr, 4'h0, instr, 32'h5555_AAAA);
        do_txn(addr, $urandom, 4'h0, instr, 32'h5555_AAAA);
        n_checks++;
        if (obs_berr !== 1'b1 || obs_rdata !== ERRD || obs_cause !== {instr, 2'b01}) begin
            n_fail++; $display("FAIL err_ack_priority: got berr=%b rdata=%h cause=%b required 1 deadbeef %b",
                               obs_berr, obs_rdata, obs_cause, {instr, 2'b01});
        end
    endtask

    task automatic test_back_to_back();
        int acc1, gap;
        scr_len = 1; scr_wait[0] = 0; scr_term[0] = TermAck;
        model_txn(32'h100, 4'h0, 1'b0, 32'h1);
        do_txn(32'h100, 32'h0, 4'h0, 1'b0, 32'h1);
        acc1 = obs_accept;
        n_checks++;
        if (obs_lat !== 1) begin n_fail++; $display("FAIL zero_wait_latency: got %0d required 1", obs_lat); end
        gap = exp_lat + 2;
        model_txn(32'h104, 4'hF, 1'b0, 32'h2);
        do_txn(32'h104, 32'h2, 4'hF, 1'b0, 32'h2);
        n_checks++;
        if (obs_accept - acc1 !== gap) begin
            n_fail++; $display("FAIL back_to_back_gap: got %0d required %0d", obs_accept - acc1, gap);
        end
    endtask

    task automatic test_random();
        logic [31:0] addr, wdata, sdat;
        logic [3:0]  wstrb;
        logic        instr;
        int          r;
        noise = 1'b1;
        for (int t = 0; t < 40; t++) begin
            addr = $urandom; wdata = $urandom; sdat = $urandom; instr = 1'($urandom);
            wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            scr_len = $urandom_range(1, 4);
            for (int i = 0; i < scr_len; i++) begin
                scr_wait[i] = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 3);
                r = $urandom_range(0, 9);
                scr_term[i] = (r < 4) ? TermAck : (r == 4) ? TermErr : (r < 8) ? TermRty :
                              (r == 8) ? TermNone : TermErrAck;
            end
            model_txn(addr, wstrb, instr, sdat);
            do_txn(addr, wdata, wstrb, instr, sdat);
            n_checks++;
            if (obs_lat !== exp_lat) begin
                n_fail++; $display("FAIL rnd%0d_latency: got %0d required %0d", t, obs_lat, exp_lat);
            end
            n_checks++;
            if (obs_rdata !== exp_rdata) begin
                n_fail++; $display("FAIL rnd%0d_rdata: got %h required %h", t, obs_rdata, exp_rdata);
            end
            n_checks++;
            if (obs_berr !== exp_berr) begin
                n_fail++; $display("FAIL rnd%0d_bus_err: got %b required %b", t, obs_berr, exp_berr);
            end
            n_checks++;
            if ({obs_eaddr, obs_cause} !== {mdl_err_addr, mdl_err_cause}) begin
                n_fail++; $display("FAIL rnd%0d_err_status: got %h/%b required %h/%b",
                                   t, obs_eaddr, obs_cause, mdl_err_addr, mdl_err_cause);
            end
            n_checks++;
            if (obs_attempts !== exp_attempts || obs_cyc !== exp_cyc) begin
                n_fail++; $display("FAIL rnd%0d_attempts: got %0d/%0d required %0d/%0d",
                                   t, obs_attempts, obs_cyc, exp_attempts, exp_cyc);
            end
            n_checks++;
            if ({obs_adr, obs_dat, obs_sel, obs_we} !==
                {addr, wdata, (wstrb == 4'h0) ? 4'hF : wstrb, wstrb != 4'h0}) begin
                n_fail++; $display("FAIL rnd%0d_bus: got adr=%h dat=%h sel=%h we=%b required %h %h %h",
                                   t, obs_adr, obs_dat, obs_sel, obs_we, addr, wdata, wstrb);
            end
            n_checks++;
            if (obs_unstable !== 0 || obs_extra !== 0) begin
                n_fail++; $display("FAIL rnd%0d_protocol: got unstable=%0d extra=%0d required 0/0",
                                   t, obs_unstable, obs_extra);
            end
        end
        noise = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic saw_ready;
        saw_ready = 1'b0;
        {wbm_ack, wbm_err, wbm_rty} = 3'b000;
        mem_valid = 1'b1; mem_addr = $urandom; mem_wstrb = 4'h0;
        @(posedge clk);
        repeat (2) @(negedge clk);
        n_checks++;
        if (wbm_cyc !== 1'b1) begin n_fail++; $display("FAIL pre_reset_cyc: got %b required 1", wbm_cyc); end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({wbm_cyc, wbm_stb} !== 2'b00) begin
            n_fail++; $display("FAIL async_reset_cyc: got %b required 00", {wbm_cyc, wbm_stb});
        end
        mem_valid = 1'b0;
        mdl_err_addr = '0; mdl_err_cause = '0;
        repeat (3) begin @(negedge clk); if (mem_ready) saw_ready = 1'b1; end
        rst_n = 1'b1;
        repeat (2) begin @(negedge clk); if (mem_ready) saw_ready = 1'b1; end
        n_checks++;
        if (saw_ready !== 1'b0) begin n_fail++; $display("FAIL reset_no_ready: got 1 required 0"); end
        n_checks++;
        if ({err_addr, err_cause} !== {mdl_err_addr, mdl_err_cause}) begin
            n_fail++; $display("FAIL reset_err_status: got %h/%b required 0/0", err_addr, err_cause);
        end
        scr_len = 1; scr_wait[0] = 1; scr_term[0] = TermAck;
        model_txn(32'h40, 4'h0, 1'b0, 32'h7777_0000);
        do_txn(32'h40, 32'h0, 4'h0, 1'b0, 32'h7777_0000);
        n_checks++;
        if (obs_lat !== exp_lat || obs_rdata !== exp_rdata) begin
            n_fail++; $display("FAIL post_reset_read: got lat=%0d rdata=%h required %0d %h",
                               obs_lat, obs_rdata, exp_lat, exp_rdata);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read();
        test_write_byte();
        test_retry_ok();
        test_retry_exhaust();
        test_timeout();
        test_err_ack();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
